// File: rtl/acl_txbuf_ctrl.sv
// ACL transmit double-buffer controller.
// Each LT_ADDR owns two payload buffers. One is "active" (being sent or
// retransmitted) and the other is the "fill" buffer that the MCU loads.
// ARQ decisions taken at the TX header start move the active pointer,
// free acknowledged buffers and drive the payload read controls.
module acl_txbuf_ctrl (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       conns,
  input  logic       m_2active_p,
  input  logic       s_2active_p,
  input  logic       pk_encode,
  input  logic       header_st_p,
  input  logic [2:0] txpk_lt_addr,
  input  logic       sendnewpy,
  input  logic       sendoldpy,
  input  logic       send0py,
  input  logic       regi_bufload_p,
  input  logic [2:0] regi_load_lt_addr,
  input  logic       regi_flushcmd_p,
  output logic [7:0] txbuf_sel,
  output logic       txpy_bufsel,
  output logic       txpy_en,
  output logic       txpy_zero,
  output logic [7:0] fillbuf_full,
  output logic       txbuf_release_p,
  output logic [2:0] release_lt_addr,
  output logic       ovf_err
);

  logic [7:0] act, v0, v1, infl;
  logic [7:0] act_n, v0_n, v1_n, infl_n;
  logic       en_n, zero_n, bsel_n, rel_n, ovf_n;
  logic [2:0] rla_n;
  logic       dec_ev, new_conn;
  logic [2:0] a, l;
  logic       cur, cur_v, oth_v, fill;

  assign dec_ev       = header_st_p & pk_encode & conns;
  assign new_conn     = m_2active_p | s_2active_p;
  assign a            = txpk_lt_addr;
  assign l            = regi_load_lt_addr;
  assign txbuf_sel    = act;
  assign fillbuf_full = v0 & v1;

  // Next-state: new connection, then ARQ decision, then flush or load.
  always_comb begin
    act_n  = act;
    v0_n   = v0;
    v1_n   = v1;
    infl_n = infl;
    en_n   = txpy_en;
    zero_n = txpy_zero;
    bsel_n = txpy_bufsel;
    rel_n  = 1'b0;
    rla_n  = release_lt_addr;
    ovf_n  = ovf_err;
    cur    = act[a];
    cur_v  = act[a] ? v1[a] : v0[a];
    oth_v  = act[a] ? v0[a] : v1[a];
    fill   = 1'b0;

    if (new_conn) begin
      act_n  = '0;
      v0_n   = '0;
      v1_n   = '0;
      infl_n = '0;
      en_n   = 1'b0;
      zero_n = 1'b0;
      bsel_n = 1'b0;
      ovf_n  = 1'b0;
    end else begin
      if (dec_ev) begin
        zero_n = 1'b0;
        bsel_n = cur;
        if (send0py) begin
          en_n   = 1'b0;
          zero_n = 1'b1;
        end else if (sendoldpy) begin
          en_n = cur_v;
        end else if (sendnewpy) begin
          // Acknowledged buffer is freed before choosing what to send next.
          if (infl[a]) begin
            if (cur) v1_n[a] = 1'b0;
            else     v0_n[a] = 1'b0;
            cur_v = 1'b0;
            rel_n = 1'b1;
            rla_n = a;
          end
          if (oth_v) begin
            act_n[a]  = ~cur;
            bsel_n    = ~cur;
            en_n      = 1'b1;
            infl_n[a] = 1'b1;
          end else if (cur_v) begin
            en_n      = 1'b1;
            infl_n[a] = 1'b1;
          end else begin
            en_n      = 1'b0;
            infl_n[a] = 1'b0;
          end
        end else begin
          en_n = 1'b0;
        end
      end

      // Flush overrides any same-address decision and any load.
      if (regi_flushcmd_p) begin
        act_n[l]  = act[l];
        v0_n[l]   = 1'b0;
        v1_n[l]   = 1'b0;
        infl_n[l] = 1'b0;
        if (dec_ev && (a == l)) begin
          en_n   = 1'b0;
          rel_n  = 1'b0;
          rla_n  = release_lt_addr;
          bsel_n = act[l];
        end
      end else if (regi_bufload_p) begin
        // Fill buffer is taken from the post-decision active pointer.
        fill = ~act_n[l];
        if (fill ? v1_n[l] : v0_n[l]) ovf_n = 1'b1;
        else if (fill)                v1_n[l] = 1'b1;
        else                          v0_n[l] = 1'b1;
      end
    end
  end

  // State and registered decision outputs.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      act             <= '0;
      v0              <= '0;
      v1              <= '0;
      infl            <= '0;
      txpy_en         <= 1'b0;
      txpy_zero       <= 1'b0;
      txpy_bufsel     <= 1'b0;
      txbuf_release_p <= 1'b0;
      release_lt_addr <= '0;
      ovf_err         <= 1'b0;
    end else begin
      act             <= act_n;
      v0              <= v0_n;
      v1              <= v1_n;
      infl            <= infl_n;
      txpy_en         <= en_n;
      txpy_zero       <= zero_n;
      txpy_bufsel     <= bsel_n;
      txbuf_release_p <= rel_n;
      release_lt_addr <= rla_n;
      ovf_err         <= ovf_n;
    end
  end

endmodule

// File: tb/tb_acl_txbuf_ctrl.sv
// Self-checking bench for acl_txbuf_ctrl: a table of one-cycle vectors with
// expected outputs pushed to a scoreboard queue, plus an async-reset sequence.
module tb_acl_txbuf_ctrl;

  logic       clk_6M = 1'b0;
  logic       rstz;
  logic       conns, m_2active_p, s_2active_p, pk_encode, header_st_p;
  logic [2:0] txpk_lt_addr, regi_load_lt_addr;
  logic       sendnewpy, sendoldpy, send0py, regi_bufload_p, regi_flushcmd_p;
  logic [7:0] txbuf_sel, fillbuf_full;
  logic       txpy_bufsel, txpy_en, txpy_zero, txbuf_release_p, ovf_err;
  logic [2:0] release_lt_addr;

  acl_txbuf_ctrl dut (
    .clk_6M(clk_6M), .rstz(rstz), .conns(conns),
    .m_2active_p(m_2active_p), .s_2active_p(s_2active_p),
    .pk_encode(pk_encode), .header_st_p(header_st_p),
    .txpk_lt_addr(txpk_lt_addr), .sendnewpy(sendnewpy),
    .sendoldpy(sendoldpy), .send0py(send0py),
    .regi_bufload_p(regi_bufload_p), .regi_load_lt_addr(regi_load_lt_addr),
    .regi_flushcmd_p(regi_flushcmd_p), .txbuf_sel(txbuf_sel),
    .txpy_bufsel(txpy_bufsel), .txpy_en(txpy_en), .txpy_zero(txpy_zero),
    .fillbuf_full(fillbuf_full), .txbuf_release_p(txbuf_release_p),
    .release_lt_addr(release_lt_addr), .ovf_err(ovf_err)
  );

  always #83 clk_6M = ~clk_6M;

  typedef struct {
    logic       conns, pke, ev;
    logic [2:0] a;
    logic       nw, old, z, load, flush;
    logic [2:0] l;
    logic       act2;
    logic       e_en, e_zero, e_bsel, e_rel;
    logic [2:0] e_rla;
    logic       e_ovf;
    logic [7:0] e_full, e_sel;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int c, pk, e, a, n, o, z, ld, fl, l, m2,
                              input int en, zr, bs, rl, rla, ov, full, sel);
    vec_t r;
    r.conns = c[0];   r.pke = pk[0];    r.ev = e[0];     r.a = a[2:0];
    r.nw = n[0];      r.old = o[0];     r.z = z[0];      r.load = ld[0];
    r.flush = fl[0];  r.l = l[2:0];     r.act2 = m2[0];
    r.e_en = en[0];   r.e_zero = zr[0]; r.e_bsel = bs[0]; r.e_rel = rl[0];
    r.e_rla = rla[2:0]; r.e_ovf = ov[0]; r.e_full = full[7:0]; r.e_sel = sel[7:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp, input int idx);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic compare(input vec_t e, input int idx);
    check("txpy_en",         {7'd0, txpy_en},         {7'd0, e.e_en},   idx);
    check("txpy_zero",       {7'd0, txpy_zero},       {7'd0, e.e_zero}, idx);
    check("txpy_bufsel",     {7'd0, txpy_bufsel},     {7'd0, e.e_bsel}, idx);
    check("txbuf_release_p", {7'd0, txbuf_release_p}, {7'd0, e.e_rel},  idx);
    check("release_lt_addr", {5'd0, release_lt_addr}, {5'd0, e.e_rla},  idx);
    check("ovf_err",         {7'd0, ovf_err},         {7'd0, e.e_ovf},  idx);
    check("fillbuf_full",    fillbuf_full,            e.e_full,         idx);
    check("txbuf_sel",       txbuf_sel,               e.e_sel,          idx);
  endtask

  task automatic drive(input vec_t v);
    conns             = v.conns;
    pk_encode         = v.pke;
    header_st_p       = v.ev;
    txpk_lt_addr      = v.a;
    sendnewpy         = v.nw;
    sendoldpy         = v.old;
    send0py           = v.z;
    regi_bufload_p    = v.load;
    regi_flushcmd_p   = v.flush;
    regi_load_lt_addr = v.l;
    m_2active_p       = v.act2;
    s_2active_p       = 1'b0;
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk_6M);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk_6M);
    #1;
    e = exp_q.pop_front();
    compare(e, idx);
  endtask

  initial begin
    vec_t idle;
    idle = mk(1,1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    drive(idle);
    rstz = 1'b0;
    repeat (2) @(posedge clk_6M);
    #1;
    compare(idle, 0);
    @(negedge clk_6M);
    rstz = 1'b1;

    //          c pk e a n o z ld fl l m2   en zr bs rl rla ov full   sel
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,1,0,  0,0,0,0,0,0,8'h00,8'h00)); // load 1 -> buf1
    tbl.push_back(mk(1,1,1,1,1,0,0,0,0,0,0,  1,0,1,0,0,0,8'h00,8'h02)); // new: toggle to buf1
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0,0,  1,0,1,0,0,0,8'h00,8'h02)); // outputs hold
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,1,0,  1,0,1,0,0,0,8'h02,8'h02)); // load 1 -> buf0, full
    tbl.push_back(mk(1,1,1,1,1,0,0,0,0,0,0,  1,0,0,1,1,0,8'h00,8'h00)); // new: release + toggle
    tbl.push_back(mk(1,1,1,1,0,1,0,0,0,0,0,  1,0,0,0,1,0,8'h00,8'h00)); // old: resend buf0
    tbl.push_back(mk(1,1,1,1,0,0,1,0,0,0,0,  0,1,0,0,1,0,8'h00,8'h00)); // zero-length
    tbl.push_back(mk(1,1,1,1,1,1,1,0,0,0,0,  0,1,0,0,1,0,8'h00,8'h00)); // send0py wins
    tbl.push_back(mk(1,1,1,1,1,1,0,0,0,0,0,  1,0,0,0,1,0,8'h00,8'h00)); // sendoldpy wins
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,3,0,  1,0,0,0,1,0,8'h00,8'h00)); // load 3 -> buf1
    tbl.push_back(mk(1,1,1,3,1,0,0,0,0,0,0,  1,0,1,0,1,0,8'h00,8'h08)); // new on 3
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,3,0,  1,0,1,0,1,0,8'h08,8'h08)); // load 3 -> full
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,3,0,  1,0,1,0,1,1,8'h08,8'h08)); // overflow
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0,1,  0,0,0,0,1,0,8'h00,8'h00)); // new connection
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,2,0,  0,0,0,0,1,0,8'h00,8'h00)); // load 2
    tbl.push_back(mk(1,1,1,2,1,0,0,0,0,0,0,  1,0,1,0,1,0,8'h00,8'h04)); // new on 2
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,2,0,  1,0,1,0,1,0,8'h04,8'h04)); // load 2 -> full
    tbl.push_back(mk(1,1,1,2,1,0,0,0,1,2,0,  0,0,1,0,1,0,8'h00,8'h04)); // flush beats new
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,5,0,  0,0,1,0,1,0,8'h00,8'h04)); // load 5 -> buf1
    tbl.push_back(mk(1,1,1,5,1,0,0,0,0,0,0,  1,0,1,0,1,0,8'h00,8'h24)); // new on 5
    tbl.push_back(mk(1,1,0,0,0,0,0,1,0,5,0,  1,0,1,0,1,0,8'h20,8'h24)); // load 5 -> buf0
    tbl.push_back(mk(1,1,1,5,1,0,0,1,0,5,0,  1,0,0,1,5,0,8'h20,8'h04)); // release+load same cycle
    tbl.push_back(mk(0,1,1,5,1,0,0,1,0,6,0,  1,0,0,0,5,0,8'h20,8'h04)); // conns=0: load only
    tbl.push_back(mk(1,0,1,5,0,1,0,0,0,0,0,  1,0,0,0,5,0,8'h20,8'h04)); // pk_encode=0: no event
    tbl.push_back(mk(1,1,0,0,0,0,0,1,1,6,0,  1,0,0,0,5,0,8'h20,8'h04)); // flush+load: no ovf

    foreach (tbl[i]) step(tbl[i], i + 1);

    // Asynchronous reset in the middle of a packet.
    @(negedge clk_6M);
    drive(idle);
    rstz = 1'b0;
    #1;
    compare(idle, 100);
    @(negedge clk_6M);
    rstz = 1'b1;
    // First decision after reset sees empty buffers and nothing in flight.
    step(mk(1,1,1,5,1,0,0,0,0,0,0, 0,0,0,0,0,0,8'h00,8'h00), 101);
    step(idle, 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
